// File: rtl/uart_cfg_if.sv
// Host-side bus of uart_cfg: runtime configuration, FIFO push/pop strobes and status/error flags.
interface uart_cfg_if #(
  parameter int DBIT     = 8,
  parameter int DVSR_BIT = 16
);
  logic [DVSR_BIT-1:0] dvsr;
  logic                par_en;
  logic                par_odd;
  logic                stop2;
  logic                rd_uart;
  logic                wr_uart;
  logic                clr_err;
  logic [DBIT-1:0]     w_data;
  logic [DBIT-1:0]     r_data;
  logic                rx_empty;
  logic                rx_full;
  logic                tx_empty;
  logic                tx_full;
  logic                err_par;
  logic                err_frame;
  logic                err_ovr;

  modport master (
    output dvsr, par_en, par_odd, stop2, rd_uart, wr_uart, clr_err, w_data,
    input  r_data, rx_empty, rx_full, tx_empty, tx_full, err_par, err_frame, err_ovr
  );

  modport slave (
    input  dvsr, par_en, par_odd, stop2, rd_uart, wr_uart, clr_err, w_data,
    output r_data, rx_empty, rx_full, tx_empty, tx_full, err_par, err_frame, err_ovr
  );
endinterface

// File: rtl/uart_cfg.sv
// uart_cfg: UART with runtime baud divisor, parity / 1-2 stop bits, sticky errors and FWFT FIFOs.
// Define UART_LOOPBACK_EN to add the loopback port (RX fed from the internal TX stream).

module uart_cfg_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_i,
  input  logic         rd_i,
  input  logic [W-1:0] w_data_i,
  output logic [W-1:0] r_data_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int DEPTH = 2 ** AW;
  localparam int CW    = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_wr, do_rd;

  assign full_o   = (cnt_q == CW'(DEPTH));
  assign empty_o  = (cnt_q == '0);
  assign do_rd    = rd_i & ~empty_o;
  // when full, a simultaneous pop frees the slot the push needs
  assign do_wr    = wr_i & (~full_o | rd_i);
  assign r_data_o = mem_q[rp_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wp_q] <= w_data_i;
        wp_q        <= wp_q + 1'b1;
      end
      if (do_rd) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_wr) - CW'(do_rd);
    end
  end
endmodule

module uart_cfg #(
  parameter int DBIT     = 8,
  parameter int OVS      = 16,
  parameter int DVSR_BIT = 16,
  parameter int FIFO_W   = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
`ifdef UART_LOOPBACK_EN
  input  logic      loopback,
`endif
  output logic      tx,
  uart_cfg_if.slave bus
);
  localparam int SW = $clog2(2 * OVS);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] HALF_LAST  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST   = SW'(OVS - 1);
  localparam logic [SW-1:0] STOP2_LAST = SW'(2 * OVS - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DVSR_BIT-1:0] tick_cnt_q, tick_cnt_d;
  logic                tick;
  logic                rx_meta_q, rx_sync_q, rx_line;

  state_t          rx_state_q, rx_state_d;
  logic [SW-1:0]   rx_s_q, rx_s_d;
  logic [NW-1:0]   rx_n_q, rx_n_d;
  logic [DBIT-1:0] rx_b_q, rx_b_d;
  logic [2:0]      rx_cfg_q, rx_cfg_d;   // {par_en, par_odd, stop2}
  logic            rx_push, set_par, set_frame, set_ovr;
  logic [DBIT-1:0] rx_head;
  logic            rx_fifo_empty, rx_fifo_full;

  state_t          tx_state_q, tx_state_d;
  logic [SW-1:0]   tx_s_q, tx_s_d;
  logic [NW-1:0]   tx_n_q, tx_n_d;
  logic [DBIT-1:0] tx_b_q, tx_b_d;
  logic [1:0]      tx_cfg_q, tx_cfg_d;   // {par_en, stop2}
  logic            tx_pbit_q, tx_pbit_d;
  logic            tx_q, tx_d, tx_pop;
  logic [DBIT-1:0] tx_head;
  logic            tx_fifo_empty, tx_fifo_full;

  logic err_par_q, err_par_d, err_frame_q, err_frame_d, err_ovr_q, err_ovr_d;

  // counter above a freshly lowered divisor wraps without emitting a tick
  always_comb begin
    tick       = 1'b0;
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (tick_cnt_q == bus.dvsr) begin
      tick       = 1'b1;
      tick_cnt_d = '0;
    end else if (tick_cnt_q > bus.dvsr) begin
      tick_cnt_d = '0;
    end
  end

`ifdef UART_LOOPBACK_EN
  assign rx_line = loopback ? tx_q : rx_sync_q;
  assign tx      = loopback ? 1'b1 : tx_q;
`else
  assign rx_line = rx_sync_q;
  assign tx      = tx_q;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_s_d     = rx_s_q;
    rx_n_d     = rx_n_q;
    rx_b_d     = rx_b_q;
    rx_cfg_d   = rx_cfg_q;
    rx_push    = 1'b0;
    set_par    = 1'b0;
    set_frame  = 1'b0;
    case (rx_state_q)
      IDLE: if (!rx_line) begin
        rx_state_d = START;
        rx_s_d     = '0;
        rx_cfg_d   = {bus.par_en, bus.par_odd, bus.stop2};
      end
      START: if (tick) begin
        if (rx_s_q == HALF_LAST) begin
          rx_s_d     = '0;
          rx_n_d     = '0;
          rx_state_d = rx_line ? IDLE : DATA;
        end else rx_s_d = rx_s_q + 1'b1;
      end
      DATA: if (tick) begin
        if (rx_s_q == BIT_LAST) begin
          rx_s_d = '0;
          rx_b_d = {rx_line, rx_b_q[DBIT-1:1]};
          if (rx_n_q == N_LAST) rx_state_d = rx_cfg_q[2] ? PARITY : STOP;
          else                  rx_n_d     = rx_n_q + 1'b1;
        end else rx_s_d = rx_s_q + 1'b1;
      end
      PARITY: if (tick) begin
        if (rx_s_q == BIT_LAST) begin
          rx_s_d     = '0;
          set_par    = rx_line != ((^rx_b_q) ^ rx_cfg_q[1]);
          rx_state_d = STOP;
        end else rx_s_d = rx_s_q + 1'b1;
      end
      STOP: if (tick) begin
        if (rx_s_q == (rx_cfg_q[0] ? STOP2_LAST : BIT_LAST)) begin
          set_frame  = ~rx_line;
          rx_push    = 1'b1;
          rx_state_d = IDLE;
        end else rx_s_d = rx_s_q + 1'b1;
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    tx_cfg_d   = tx_cfg_q;
    tx_pbit_d  = tx_pbit_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      IDLE: if (!tx_fifo_empty) begin
        tx_pop     = 1'b1;
        tx_b_d     = tx_head;
        tx_pbit_d  = (^tx_head) ^ bus.par_odd;
        tx_cfg_d   = {bus.par_en, bus.stop2};
        tx_s_d     = '0;
        tx_state_d = START;
      end
      START: if (tick) begin
        if (tx_s_q == BIT_LAST) begin
          tx_s_d     = '0;
          tx_n_d     = '0;
          tx_state_d = DATA;
        end else tx_s_d = tx_s_q + 1'b1;
      end
      DATA: if (tick) begin
        if (tx_s_q == BIT_LAST) begin
          tx_s_d = '0;
          if (tx_n_q == N_LAST) begin
            tx_state_d = tx_cfg_q[1] ? PARITY : STOP;
          end else begin
            tx_n_d = tx_n_q + 1'b1;
            tx_b_d = {1'b0, tx_b_q[DBIT-1:1]};
          end
        end else tx_s_d = tx_s_q + 1'b1;
      end
      PARITY: if (tick) begin
        if (tx_s_q == BIT_LAST) begin
          tx_s_d     = '0;
          tx_state_d = STOP;
        end else tx_s_d = tx_s_q + 1'b1;
      end
      STOP: if (tick) begin
        if (tx_s_q == (tx_cfg_q[0] ? STOP2_LAST : BIT_LAST)) tx_state_d = IDLE;
        else tx_s_d = tx_s_q + 1'b1;
      end
      default: tx_state_d = IDLE;
    endcase
    // line level is registered from the upcoming state so it changes on the transition edge
    case (tx_state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = tx_b_d[0];
      PARITY:  tx_d = tx_pbit_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign set_ovr     = rx_push & rx_fifo_full & ~bus.rd_uart;
  assign err_par_d   = (err_par_q   & ~bus.clr_err) | set_par;
  assign err_frame_d = (err_frame_q & ~bus.clr_err) | set_frame;
  assign err_ovr_d   = (err_ovr_q   & ~bus.clr_err) | set_ovr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= IDLE;
      rx_s_q      <= '0;
      rx_n_q      <= '0;
      rx_b_q      <= '0;
      rx_cfg_q    <= '0;
      tx_state_q  <= IDLE;
      tx_s_q      <= '0;
      tx_n_q      <= '0;
      tx_b_q      <= '0;
      tx_cfg_q    <= '0;
      tx_pbit_q   <= 1'b0;
      tx_q        <= 1'b1;
      err_par_q   <= 1'b0;
      err_frame_q <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_s_q      <= rx_s_d;
      rx_n_q      <= rx_n_d;
      rx_b_q      <= rx_b_d;
      rx_cfg_q    <= rx_cfg_d;
      tx_state_q  <= tx_state_d;
      tx_s_q      <= tx_s_d;
      tx_n_q      <= tx_n_d;
      tx_b_q      <= tx_b_d;
      tx_cfg_q    <= tx_cfg_d;
      tx_pbit_q   <= tx_pbit_d;
      tx_q        <= tx_d;
      err_par_q   <= err_par_d;
      err_frame_q <= err_frame_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  uart_cfg_fifo #(.W(DBIT), .AW(FIFO_W)) rx_fifo (
    .clk(clk), .reset(reset), .wr_i(rx_push), .rd_i(bus.rd_uart), .w_data_i(rx_b_q),
    .r_data_o(rx_head), .empty_o(rx_fifo_empty), .full_o(rx_fifo_full)
  );

  uart_cfg_fifo #(.W(DBIT), .AW(FIFO_W)) tx_fifo (
    .clk(clk), .reset(reset), .wr_i(bus.wr_uart), .rd_i(tx_pop), .w_data_i(bus.w_data),
    .r_data_o(tx_head), .empty_o(tx_fifo_empty), .full_o(tx_fifo_full)
  );

  assign bus.r_data    = rx_head;
  assign bus.rx_empty  = rx_fifo_empty;
  assign bus.rx_full   = rx_fifo_full;
  assign bus.tx_empty  = tx_fifo_empty;
  assign bus.tx_full   = tx_fifo_full;
  assign bus.err_par   = err_par_q;
  assign bus.err_frame = err_frame_q;
  assign bus.err_ovr   = err_ovr_q;
endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: RX/TX vector tables plus hand-written overrun, glitch, stop-gap and reset sequences.
module tb_uart_cfg;
  localparam int BIT = 64;   // dvsr=3, OVS=16 -> 64 clocks per bit

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic tx;
  int   errors = 0;
  int   checks = 0;

  uart_cfg_if #(.DBIT(8), .DVSR_BIT(16)) bus ();

  uart_cfg #(.DBIT(8), .OVS(16), .DVSR_BIT(16), .FIFO_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .tx(tx),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         pen;
    bit         podd;
    bit         s2;
    bit         pbit;      // parity bit actually driven on rx
    bit         stop_ok;   // 0 -> stop bit driven low
    bit         exp_par;
    bit         exp_frame;
  } rxv_t;

  typedef struct {
    logic [7:0] data;
    bit         pen;
    bit         podd;
    bit         s2;
    bit         exp_pbit;
  } txv_t;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rx_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] d, input bit pen, input bit pbit, input bit s2, input bit stop_ok);
    rx_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) rx_bit(d[i], BIT);
    if (pen) rx_bit(pbit, BIT);
    if (s2) rx_bit(1'b1, BIT);
    if (stop_ok) rx_bit(1'b1, BIT);
    else begin
      rx_bit(1'b0, 40);
      rx_bit(1'b1, 24);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus.w_data  = d;
    bus.wr_uart = 1'b1;
    @(negedge clk);
    bus.wr_uart = 1'b0;
  endtask

  task automatic pop_rx;
    bus.rd_uart = 1'b1;
    @(negedge clk);
    bus.rd_uart = 1'b0;
  endtask

  task automatic pulse_clr;
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  task automatic wait_tx_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic capture_tx(input int nb, output logic [15:0] got, output int lowrun,
                            output bit ok, output logic emp_at_start);
    bit inrun;
    got = '1;
    lowrun = 0;
    inrun = 1'b1;
    emp_at_start = 1'bx;
    wait_tx_low(ok);
    if (ok) begin
      emp_at_start = bus.tx_empty;
      for (int i = 0; i < nb * BIT; i++) begin
        if (inrun && tx === 1'b0) lowrun++;
        else inrun = 1'b0;
        if (i % BIT == BIT / 2) got[i / BIT] = tx;
        @(negedge clk);
      end
    end
  endtask

  task automatic measure_gap(output int gap, output bit ok);
    bit seen_high;
    seen_high = 1'b0;
    gap = 0;
    wait_tx_low(ok);
    if (ok) begin
      ok = 1'b0;
      for (int i = 1; i < 2000; i++) begin
        @(negedge clk);
        if (tx === 1'b1) seen_high = 1'b1;
        else if (seen_high) begin
          gap = i;
          ok = 1'b1;
          break;
        end
      end
    end
  endtask

  initial begin
    rxv_t        rxv[7];
    txv_t        txv[4];
    logic [7:0]  ovr_d[5];
    logic [15:0] got, exp;
    int          lowrun, nb, gap, lows;
    bit          ok;
    logic        emp;

    rxv[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rxv[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    rxv[2] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    rxv[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rxv[4] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    rxv[5] = '{8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    rxv[6] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    txv[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    txv[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1};
    txv[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
    txv[3] = '{8'h3D, 1'b0, 1'b0, 1'b1, 1'b0};

    ovr_d[0] = 8'h11; ovr_d[1] = 8'h22; ovr_d[2] = 8'h33; ovr_d[3] = 8'h44; ovr_d[4] = 8'h55;

    reset = 1'b1;
    rx = 1'b1;
    bus.dvsr = 16'd3;
    bus.par_en = 1'b0;
    bus.par_odd = 1'b0;
    bus.stop2 = 1'b0;
    bus.rd_uart = 1'b0;
    bus.wr_uart = 1'b0;
    bus.clr_err = 1'b0;
    bus.w_data = '0;
    repeat (3) @(negedge clk);

    check1("rst_tx", tx, 1'b1);
    check1("rst_rx_empty", bus.rx_empty, 1'b1);
    check1("rst_rx_full", bus.rx_full, 1'b0);
    check1("rst_tx_empty", bus.tx_empty, 1'b1);
    check1("rst_tx_full", bus.tx_full, 1'b0);
    check16("rst_r_data", {8'h00, bus.r_data}, 16'h0000);
    check1("rst_err_par", bus.err_par, 1'b0);
    check1("rst_err_frame", bus.err_frame, 1'b0);
    check1("rst_err_ovr", bus.err_ovr, 1'b0);
    $display("reset: tx=%b rx_empty=%b tx_empty=%b r_data=%h", tx, bus.rx_empty, bus.tx_empty, bus.r_data);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    foreach (rxv[v]) begin
      bus.par_en = rxv[v].pen;
      bus.par_odd = rxv[v].podd;
      bus.stop2 = rxv[v].s2;
      @(negedge clk);
      send_rx(rxv[v].data, rxv[v].pen, rxv[v].pbit, rxv[v].s2, rxv[v].stop_ok);
      $display("rx vec %0d: sent=%h r_data=%h empty=%b par=%b frame=%b ovr=%b", v, rxv[v].data,
               bus.r_data, bus.rx_empty, bus.err_par, bus.err_frame, bus.err_ovr);
      check16($sformatf("rx%0d_data", v), {8'h00, bus.r_data}, {8'h00, rxv[v].data});
      check1($sformatf("rx%0d_empty", v), bus.rx_empty, 1'b0);
      check1($sformatf("rx%0d_err_par", v), bus.err_par, rxv[v].exp_par);
      check1($sformatf("rx%0d_err_frame", v), bus.err_frame, rxv[v].exp_frame);
      check1($sformatf("rx%0d_err_ovr", v), bus.err_ovr, 1'b0);
      pulse_clr();
      check1($sformatf("rx%0d_clr_par", v), bus.err_par, 1'b0);
      check1($sformatf("rx%0d_clr_frame", v), bus.err_frame, 1'b0);
      pop_rx();
      check1($sformatf("rx%0d_empty_after_pop", v), bus.rx_empty, 1'b1);
      repeat (100) @(negedge clk);
    end

    foreach (txv[v]) begin
      bus.par_en = txv[v].pen;
      bus.par_odd = txv[v].podd;
      bus.stop2 = txv[v].s2;
      nb = 10 + int'(txv[v].pen) + int'(txv[v].s2);
      exp = '1;
      exp[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp[1 + i] = txv[v].data[i];
      if (txv[v].pen) exp[9] = txv[v].exp_pbit;
      write_byte(txv[v].data);
      capture_tx(nb, got, lowrun, ok, emp);
      $display("tx vec %0d: data=%h bits=%h expected=%h lowrun=%0d", v, txv[v].data, got, exp, lowrun);
      check1($sformatf("tx%0d_started", v), ok, 1'b1);
      check1($sformatf("tx%0d_empty_after_pop", v), emp, 1'b1);
      check16($sformatf("tx%0d_bits", v), got, exp);
      if (txv[v].data[0]) check1($sformatf("tx%0d_start_len", v), (lowrun >= 61 && lowrun <= 64), 1'b1);
      repeat (40) @(negedge clk);
    end

    for (int s = 0; s < 2; s++) begin
      bus.par_en = 1'b0;
      bus.stop2 = (s == 1);
      write_byte(8'h00);
      write_byte(8'h00);
      measure_gap(gap, ok);
      $display("tx gap stop2=%0d: %0d clocks", s, gap);
      check1($sformatf("gap%0d_seen", s), ok, 1'b1);
      if (s == 1) check1("gap_stop2", (gap >= 700 && gap <= 707), 1'b1);
      else        check1("gap_stop1", (gap >= 636 && gap <= 643), 1'b1);
      repeat (800) @(negedge clk);
    end

    bus.par_en = 1'b0;
    bus.stop2 = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      send_rx(ovr_d[k], 1'b0, 1'b0, 1'b0, 1'b1);
      $display("ovr frame %0d: sent=%h full=%b ovr=%b", k, ovr_d[k], bus.rx_full, bus.err_ovr);
      if (k == 3) begin
        check1("ovr_full_at4", bus.rx_full, 1'b1);
        check1("ovr_no_err_at4", bus.err_ovr, 1'b0);
      end
      repeat (10) @(negedge clk);
    end
    check1("ovr_err", bus.err_ovr, 1'b1);
    check1("ovr_full", bus.rx_full, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check16($sformatf("ovr_read%0d", k), {8'h00, bus.r_data}, {8'h00, ovr_d[k]});
      pop_rx();
    end
    check1("ovr_empty_after_reads", bus.rx_empty, 1'b1);
    check1("ovr_not_full_after_reads", bus.rx_full, 1'b0);
    pulse_clr();
    check1("ovr_clr", bus.err_ovr, 1'b0);

    rx_bit(1'b0, 16);
    rx_bit(1'b1, 200);
    $display("glitch: rx_empty=%b par=%b frame=%b ovr=%b", bus.rx_empty, bus.err_par, bus.err_frame, bus.err_ovr);
    check1("glitch_empty", bus.rx_empty, 1'b1);
    check1("glitch_err_par", bus.err_par, 1'b0);
    check1("glitch_err_frame", bus.err_frame, 1'b0);
    check1("glitch_err_ovr", bus.err_ovr, 1'b0);

    write_byte(8'hFF);
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    check1("rst_mid_tx_full", bus.tx_full, 1'b1);
    wait_tx_low(ok);
    check1("rst_mid_started", ok, 1'b1);
    repeat (20) @(negedge clk);
    check1("rst_mid_tx_low_before", tx, 1'b0);
    reset = 1'b1;
    #1;
    check1("rst_mid_tx_high", tx, 1'b1);
    check1("rst_mid_tx_empty", bus.tx_empty, 1'b1);
    check1("rst_mid_tx_not_full", bus.tx_full, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    $display("reset mid-tx: low samples after release=%0d", lows);
    check16("rst_mid_no_frames", lows[15:0], 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
